i2c_reg_seq: RTL
================

# i2c_reg_seq

Parametrised I2C register-sequence configurator: after a power-up delay it walks an external register table and writes every entry to one I2C slave through the byte-level I2C master (req/cmd/dout/done handshake), optionally reading each register back to verify it. It generalises the fixed-table HDMI transmitter configurator to 8- or 16-bit register addresses, arbitrary table depth, NACK/mismatch retry and an error flag. It sits between the top-level init logic and the shared I2C master, and is instantiated once per configurable device (HDMI transmitter, CMOS sensor).

## Interface
- DEV_ID, 8'h72: 8-bit slave write address; read address is DEV_ID|1.
- AW_BYTES, 1: register address bytes, 1 or 2, MSB first.
- DEPTH, 31: table entries, 1..1024.
- DELAY, 1000: power-up wait in clk cycles, ≥1.
- VERIFY, 0: 1 = read back and compare each entry after writing it.
- MAX_RETRY, 3: extra attempts per entry after NACK/mismatch, 0..7.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- reinit_n  in  1  level, active low; restarts the sequence once config is finished or failed (e.g. HPD interrupt).
- tbl_addr  out  10  table index of the current entry.
- tbl_data  in  8*AW_BYTES+8  {reg_addr, reg_data}, combinational from tbl_addr.
- req  out  1  one-cycle byte request to the I2C master.
- cmd  out  4  command bits: START, WRITE, READ, STOP.
- dout  out  8  byte to transmit.
- din  in  8  byte received, valid with done after a READ.
- done  in  1  one-cycle pulse, byte finished.
- ack_err  in  1  sampled with done; 1 = slave NACK.
- config_done  out  1  table written successfully.
- config_err  out  1  entry exceeded MAX_RETRY.

## Operation
- States: WAIT, IDLE, REQ, XFER, CHECK, FIN, FAIL.
- WAIT: counts DELAY cycles, then IDLE. Only entered from reset.
- IDLE: entry index idx=0, retry count=0, byte index b=0, then REQ.
- REQ: one cycle; registered req=1 with cmd/dout for byte b, then XFER.
- Write frame (NB=AW_BYTES+2 bytes): b0 START|WRITE, DEV_ID; address bytes WRITE; last byte WRITE|STOP, reg_data.
- Verify frame (VERIFY=1, after the write frame): START|WRITE DEV_ID; address bytes WRITE; START|WRITE DEV_ID|1; READ|STOP. The last data byte is latched from din.
- XFER: wait for done. If ack_err=1 on any non-READ byte, the frame is aborted: one STOP-only byte is issued, then CHECK with fail. Otherwise b++ and back to REQ, or CHECK after the last byte.
- CHECK: pass when there was no NACK and, with VERIFY=1, the read byte equals reg_data.
  - Pass: idx++, retry=0, b=0. If idx==DEPTH-1 the next state is FIN.
  - Fail: retry++ and the entry restarts from its write frame. If retry==MAX_RETRY, go to FAIL.
- FIN: config_done=1. FAIL: config_err=1. In both, reinit_n=0 clears the flag and goes to IDLE (no DELAY).
- reinit_n is ignored in WAIT/IDLE/REQ/XFER/CHECK; an in-flight sequence is never interrupted.

## Timing
- Reset values:
  - req=0, cmd=0, dout=0, tbl_addr=0, config_done=0, config_err=0.
  - state=WAIT, all counters 0.
- cmd/dout are valid only while req=1; they are 0 otherwise.
- Exactly one outstanding byte. req fires the cycle after entering REQ. The next req fires no earlier than 2 cycles after done.
- done arriving outside XFER is ignored. A done in the same cycle as reinit_n falling is handled by XFER first.
- config_done/config_err rise 1 cycle after the final CHECK. They are mutually exclusive and both drop 1 cycle after reinit_n is sampled low in FIN/FAIL.
- Asynchronous reset mid-frame: all outputs go low immediately and the FSM restarts in WAIT. The master is expected to be reset with the same rst_n.

## Structure
- Shared package/header: CMD_START/WRITE/READ/STOP bit constants (1,2,4,8) and the state encodings (one-hot, 7 bits).
- The table is external: a per-device ROM module (e.g. adv7513_lut) maps tbl_addr to tbl_data, so the same configurator serves any device.
- Natural sub-module: i2c_frame_gen, which is combinational and maps (b, mode write/verify, AW_BYTES, tbl_data) to {cmd, dout, last}.

## Test plan
- DEPTH=3, AW_BYTES=1, DELAY=10, VERIFY=0, slave model ACKs all:
  - 9 req pulses, bytes 72/reg/data per entry, STOP only on every 3rd byte.
  - config_done rises; first req comes 11 cycles after reset release.
- AW_BYTES=2, DEV_ID=8'h78, entry {16'h3008,8'h82}:
  - bytes 78(START|WRITE), 30, 08, 82(WRITE|STOP).
- VERIFY=1, slave returns written data:
  - write frame followed by 78?/reg/79/READ|STOP frame; config_done=1, config_err=0.
- NACK on entry 1 twice, then ACK, MAX_RETRY=3:
  - entry 1 is sent 3 times; tbl_addr advances after that; config_done=1.
- Permanent mismatch with VERIFY=1, MAX_RETRY=2:
  - 3 attempts; config_err=1, config_done=0, no further req.
- After config_done, pulse reinit_n low for 1 cycle:
  - config_done drops; the sequence restarts at idx 0 with no DELAY.
- Async reset asserted mid-frame:
  - req=0 at once; after release the delay runs again.

Source files
------------

// File: rtl/i2c_reg_seq_pkg.sv
// Shared definitions for the I2C register-sequence configurator.
//   CMD_*   : command bits presented to the byte-level I2C master on cmd.
//   state_e : one-hot sequencer state encoding.
package i2c_reg_seq_pkg;

    localparam logic [3:0] CMD_START = 4'd1;
    localparam logic [3:0] CMD_WRITE = 4'd2;
    localparam logic [3:0] CMD_READ  = 4'd4;
    localparam logic [3:0] CMD_STOP  = 4'd8;

    typedef enum logic [6:0] {
        ST_WAIT  = 7'b0000001,
        ST_IDLE  = 7'b0000010,
        ST_REQ   = 7'b0000100,
        ST_XFER  = 7'b0001000,
        ST_CHECK = 7'b0010000,
        ST_FIN   = 7'b0100000,
        ST_FAIL  = 7'b1000000
    } state_e;

endpackage

// File: rtl/i2c_reg_seq_frame_gen.sv
// Combinational byte generator for one I2C frame of a table entry.
// Ports:
//   b_i        : byte index within the current frame
//   verify_i   : 0 = write frame, 1 = read-back (verify) frame
//   tbl_data_i : {reg_addr, reg_data} of the current entry
//   cmd_o      : command bits for byte b_i
//   dout_o     : byte to transmit (0 for the READ byte)
//   last_o     : byte b_i is the final byte of the frame
// Write frame : START|WRITE dev, WRITE addr bytes (MSB first), WRITE|STOP data.
// Verify frame: START|WRITE dev, WRITE addr bytes, START|WRITE dev|1, READ|STOP.
module i2c_reg_seq_frame_gen
    import i2c_reg_seq_pkg::*;
#(
    parameter logic [7:0]  DEV_ID   = 8'h72,
    parameter int unsigned AW_BYTES = 1
) (
    input  logic [2:0]              b_i,
    input  logic                    verify_i,
    input  logic [8*AW_BYTES+7:0]   tbl_data_i,
    output logic [3:0]              cmd_o,
    output logic [7:0]              dout_o,
    output logic                    last_o
);

    localparam logic [2:0] B_ADDR_LAST = 3'(AW_BYTES);
    localparam logic [2:0] B_DATA      = 3'(AW_BYTES + 1);
    localparam logic [2:0] B_READ      = 3'(AW_BYTES + 2);

    always_comb begin
        cmd_o  = '0;
        dout_o = '0;
        last_o = 1'b0;
        if (b_i == 3'd0) begin
            cmd_o  = CMD_START | CMD_WRITE;
            dout_o = DEV_ID;
        end else if (b_i <= B_ADDR_LAST) begin
            cmd_o = CMD_WRITE;
            // Byte 1 carries the most significant address byte.
            for (int unsigned i = 0; i < AW_BYTES; i++) begin
                if (b_i == 3'(i + 1)) begin
                    dout_o = tbl_data_i[8 + 8*(AW_BYTES-1-i) +: 8];
                end
            end
        end else if (b_i == B_DATA) begin
            if (verify_i) begin
                cmd_o  = CMD_START | CMD_WRITE;
                dout_o = DEV_ID | 8'h01;
            end else begin
                cmd_o  = CMD_WRITE | CMD_STOP;
                dout_o = tbl_data_i[7:0];
                last_o = 1'b1;
            end
        end else if (verify_i && (b_i == B_READ)) begin
            cmd_o  = CMD_READ | CMD_STOP;
            last_o = 1'b1;
        end
    end

endmodule

// File: rtl/i2c_reg_seq.sv
// I2C register-sequence configurator: after a power-up delay, writes every
// entry of an external register table to one slave through the byte-level
// I2C master, optionally reading each register back, with per-entry retry.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   reinit_n       : restart request, honoured only in FIN/FAIL
//   tbl_addr       : index of the current table entry
//   tbl_data       : {reg_addr, reg_data} for tbl_addr (combinational ROM)
//   req/cmd/dout   : one-cycle byte request to the I2C master
//   din/done/ack_err : byte completion from the I2C master
//   config_done    : whole table written (and verified)
//   config_err     : an entry exhausted its retries
module i2c_reg_seq
    import i2c_reg_seq_pkg::*;
#(
    parameter logic [7:0]  DEV_ID    = 8'h72,
    parameter int unsigned AW_BYTES  = 1,
    parameter int unsigned DEPTH     = 31,
    parameter int unsigned DELAY     = 1000,
    parameter int unsigned VERIFY    = 0,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    reinit_n,
    output logic [9:0]              tbl_addr,
    input  logic [8*AW_BYTES+7:0]   tbl_data,
    output logic                    req,
    output logic [3:0]              cmd,
    output logic [7:0]              dout,
    input  logic [7:0]              din,
    input  logic                    done,
    input  logic                    ack_err,
    output logic                    config_done,
    output logic                    config_err
);

    localparam int unsigned DW = (DELAY > 1) ? $clog2(DELAY) : 1;

    state_e         state_q;
    logic [DW-1:0]  dly_q;
    logic [9:0]     idx_q;
    logic [2:0]     retry_q;
    logic [2:0]     b_q;
    logic           vphase_q;   // 1 while sending the read-back frame
    logic           nack_q;     // a NACK was seen during this attempt
    logic           abort_q;    // the in-flight byte is the STOP-only abort
    logic [7:0]     rdata_q;
    logic           req_q;
    logic [3:0]     cmd_q;
    logic [7:0]     dout_q;
    logic           done_q;
    logic           err_q;

    logic [3:0]     fg_cmd;
    logic [7:0]     fg_dout;
    logic           fg_last;
    logic           entry_ok;
    logic           is_read;

    i2c_reg_seq_frame_gen #(
        .DEV_ID   (DEV_ID),
        .AW_BYTES (AW_BYTES)
    ) u_frame_gen (
        .b_i        (b_q),
        .verify_i   (vphase_q),
        .tbl_data_i (tbl_data),
        .cmd_o      (fg_cmd),
        .dout_o     (fg_dout),
        .last_o     (fg_last)
    );

    assign is_read  = (fg_cmd & CMD_READ) != '0;
    assign entry_ok = !nack_q && ((VERIFY == 0) || (rdata_q == tbl_data[7:0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_WAIT;
            dly_q    <= '0;
            idx_q    <= '0;
            retry_q  <= '0;
            b_q      <= '0;
            vphase_q <= 1'b0;
            nack_q   <= 1'b0;
            abort_q  <= 1'b0;
            rdata_q  <= '0;
            req_q    <= 1'b0;
            cmd_q    <= '0;
            dout_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // cmd/dout are only non-zero alongside req.
            req_q  <= 1'b0;
            cmd_q  <= '0;
            dout_q <= '0;
            unique case (state_q)
                ST_WAIT: begin
                    if (dly_q == DW'(DELAY - 1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        dly_q <= dly_q + DW'(1);
                    end
                end
                ST_IDLE: begin
                    idx_q    <= '0;
                    retry_q  <= '0;
                    b_q      <= '0;
                    vphase_q <= 1'b0;
                    nack_q   <= 1'b0;
                    abort_q  <= 1'b0;
                    state_q  <= ST_REQ;
                end
                ST_REQ: begin
                    req_q   <= 1'b1;
                    cmd_q   <= abort_q ? CMD_STOP : fg_cmd;
                    dout_q  <= abort_q ? 8'h00 : fg_dout;
                    state_q <= ST_XFER;
                end
                ST_XFER: begin
                    if (done) begin
                        if (abort_q) begin
                            state_q <= ST_CHECK;
                        end else if (ack_err && !is_read) begin
                            // Release the bus with a lone STOP before retrying.
                            nack_q  <= 1'b1;
                            abort_q <= 1'b1;
                            state_q <= ST_REQ;
                        end else begin
                            if (is_read) begin
                                rdata_q <= din;
                            end
                            if (!fg_last) begin
                                b_q     <= b_q + 3'd1;
                                state_q <= ST_REQ;
                            end else if ((VERIFY != 0) && !vphase_q) begin
                                vphase_q <= 1'b1;
                                b_q      <= '0;
                                state_q  <= ST_REQ;
                            end else begin
                                state_q <= ST_CHECK;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    b_q      <= '0;
                    vphase_q <= 1'b0;
                    nack_q   <= 1'b0;
                    abort_q  <= 1'b0;
                    if (entry_ok) begin
                        retry_q <= '0;
                        if (idx_q == 10'(DEPTH - 1)) begin
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end else begin
                            idx_q   <= idx_q + 10'd1;
                            state_q <= ST_REQ;
                        end
                    end else if (retry_q == 3'(MAX_RETRY)) begin
                        err_q   <= 1'b1;
                        state_q <= ST_FAIL;
                    end else begin
                        retry_q <= retry_q + 3'd1;
                        state_q <= ST_REQ;
                    end
                end
                ST_FIN, ST_FAIL: begin
                    if (!reinit_n) begin
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_WAIT;
                end
            endcase
        end
    end

    assign tbl_addr    = idx_q;
    assign req         = req_q;
    assign cmd         = cmd_q;
    assign dout        = dout_q;
    assign config_done = done_q;
    assign config_err  = err_q;

endmodule
